// File: rtl/rs485_rx_words.sv
// rs485_rx_words
//   Receives 10-bit UART-style frames (start 0, 8 data bits MSB first, stop 1)
//   from an RS-485 line and packs every three accepted bytes into one 18-bit
//   word: byte0 -> word[15:8], byte1 -> word[7:0], byte2[7:6] -> word[17:16],
//   byte2[5:0] are pad bits that should be zero. Words are numbered 0..WORDS-1
//   within a block. A stalled link (idle longer than GAP_MAX mid-word or
//   mid-block) drops the partial word and restarts the block.
//
// Ports
//   clk80MHz     in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_en        in   receive enable; low forces idle and clears word/block state
//   rs485_rx     in   asynchronous serial line, idles high
//   data_out     out  [17:0] last assembled word (holds until the next one)
//   data_valid   out  one-cycle strobe when data_out updates
//   word_idx     out  [6:0] index of the word on data_out
//   block_done   out  one-cycle strobe with data_valid for the last word of a block
//   frame_err    out  one-cycle strobe on a bad stop bit
//   pad_err      out  one-cycle strobe with data_valid when pad bits are nonzero
//   timeout_err  out  one-cycle strobe when the inter-frame gap exceeds GAP_MAX
//
// Bit FSM
//   state   | meaning
//   S_IDLE  | line idle, waiting for a synchronized 1->0 edge; gap timer runs
//   S_START | counting to mid start bit; line high there means a glitch
//   S_DATA  | sampling 8 data bits, one per CLKS_PER_BIT clocks
//   S_STOP  | sampling the stop bit, then accepting or rejecting the byte
module rs485_rx_words #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_MAX      = 480,
    parameter int WORDS        = 97
) (
    input  logic        clk80MHz,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        rs485_rx,
    output logic [17:0] data_out,
    output logic        data_valid,
    output logic [6:0]  word_idx,
    output logic        block_done,
    output logic        frame_err,
    output logic        pad_err,
    output logic        timeout_err
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int GW = $clog2(GAP_MAX + 1) + 1;
    localparam logic [TW-1:0] HALF_TC   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_TC    = TW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_TC    = GW'(GAP_MAX);
    localparam logic [6:0]    LAST_WORD = 7'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q;
    logic           rx_meta_q;
    logic           rx_sync_q;
    logic           rx_prev_q;
    logic [TW-1:0]  tick_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic [1:0]     phase_q;
    logic [15:0]    word_lo_q;
    logic [6:0]     word_cnt_q;
    logic [GW-1:0]  gap_q;

    logic [17:0]    data_out_q;
    logic           data_valid_q;
    logic [6:0]     word_idx_q;
    logic           block_done_q;
    logic           frame_err_q;
    logic           pad_err_q;
    logic           timeout_err_q;

    logic           start_det_d;
    logic           gap_active_d;
    logic [7:0]     shift_d;

    assign start_det_d  = rx_prev_q & ~rx_sync_q;
    // The gap timer only matters while a word or a block is in progress.
    assign gap_active_d = (phase_q != 2'd0) || (word_cnt_q != 7'd0);
    assign shift_d      = {shift_q[6:0], rx_sync_q};

    always_ff @(posedge clk80MHz) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            tick_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            phase_q       <= '0;
            word_lo_q     <= '0;
            word_cnt_q    <= '0;
            gap_q         <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            word_idx_q    <= '0;
            block_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            pad_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            rx_meta_q     <= rs485_rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            data_valid_q  <= 1'b0;
            block_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            pad_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;

            if (!rx_en) begin
                state_q    <= S_IDLE;
                tick_q     <= '0;
                bit_cnt_q  <= '0;
                phase_q    <= '0;
                word_lo_q  <= '0;
                word_cnt_q <= '0;
                gap_q      <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_det_d) begin
                            state_q <= S_START;
                            tick_q  <= '0;
                            gap_q   <= '0;
                        end else if (gap_active_d) begin
                            if (gap_q == GAP_TC) begin
                                // This idle clock would be GAP_MAX+1: link stalled.
                                timeout_err_q <= 1'b1;
                                phase_q       <= '0;
                                word_cnt_q    <= '0;
                                word_lo_q     <= '0;
                                gap_q         <= '0;
                            end else begin
                                gap_q <= gap_q + GW'(1);
                            end
                        end
                    end

                    S_START: begin
                        if (tick_q == HALF_TC) begin
                            tick_q    <= '0;
                            bit_cnt_q <= '0;
                            state_q   <= rx_sync_q ? S_IDLE : S_DATA;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end

                    S_DATA: begin
                        if (tick_q == BIT_TC) begin
                            tick_q    <= '0;
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end

                    S_STOP: begin
                        if (tick_q == BIT_TC) begin
                            tick_q  <= '0;
                            state_q <= S_IDLE;
                            if (rx_sync_q) begin
                                case (phase_q)
                                    2'd0: begin
                                        word_lo_q[15:8] <= shift_q;
                                        phase_q         <= 2'd1;
                                    end
                                    2'd1: begin
                                        word_lo_q[7:0] <= shift_q;
                                        phase_q        <= 2'd2;
                                    end
                                    default: begin
                                        data_out_q   <= {shift_q[7:6], word_lo_q};
                                        data_valid_q <= 1'b1;
                                        word_idx_q   <= word_cnt_q;
                                        pad_err_q    <= (shift_q[5:0] != 6'd0);
                                        phase_q      <= 2'd0;
                                        word_lo_q    <= '0;
                                        if (word_cnt_q == LAST_WORD) begin
                                            block_done_q <= 1'b1;
                                            word_cnt_q   <= '0;
                                        end else begin
                                            word_cnt_q <= word_cnt_q + 7'd1;
                                        end
                                    end
                                endcase
                            end else begin
                                // Bad stop bit: resynchronize on the next word boundary,
                                // but keep the position within the block.
                                frame_err_q <= 1'b1;
                                phase_q     <= '0;
                                word_lo_q   <= '0;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign word_idx    = word_idx_q;
    assign block_done  = block_done_q;
    assign frame_err   = frame_err_q;
    assign pad_err     = pad_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rs485_rx_words.sv
module tb_rs485_rx_words;

    localparam int CLKS    = 16;
    localparam int GAP_MAX = 480;
    localparam int WORDS   = 97;

    logic        clk80MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        rx_en    = 1'b1;
    logic        rs485_rx = 1'b1;
    logic [17:0] data_out;
    logic        data_valid;
    logic [6:0]  word_idx;
    logic        block_done;
    logic        frame_err;
    logic        pad_err;
    logic        timeout_err;

    rs485_rx_words #(
        .CLKS_PER_BIT (CLKS),
        .GAP_MAX      (GAP_MAX),
        .WORDS        (WORDS)
    ) dut (
        .clk80MHz    (clk80MHz),
        .rst         (rst),
        .rx_en       (rx_en),
        .rs485_rx    (rs485_rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .word_idx    (word_idx),
        .block_done  (block_done),
        .frame_err   (frame_err),
        .pad_err     (pad_err),
        .timeout_err (timeout_err)
    );

    always #5 clk80MHz = ~clk80MHz;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed deliveries: {block_done, pad_err, word_idx, data_out}
    logic [26:0] got_mem [0:1023];
    int          n_got       = 0;
    int          fe_cnt      = 0;
    int          te_cnt      = 0;
    int          overlap_cnt = 0;
    int          orphan_cnt  = 0;
    int          long_cnt    = 0;
    logic [4:0]  prev_strb   = '0;

    always @(negedge clk80MHz) begin
        logic [4:0] cur;
        cur = {data_valid, block_done, frame_err, pad_err, timeout_err};
        if (data_valid && n_got < 1024) begin
            got_mem[n_got] = {block_done, pad_err, word_idx, data_out};
            n_got++;
        end
        if (frame_err)   fe_cnt++;
        if (timeout_err) te_cnt++;
        if (data_valid && (frame_err || timeout_err)) overlap_cnt++;
        if ((block_done || pad_err) && !data_valid) orphan_cnt++;
        if (|(cur & prev_strb)) long_cnt++;
        prev_strb = cur;
    end

    // Reference model: a word's position in the block is a plain integer.
    logic [26:0] exp_q [$];
    int          model_idx = 0;

    task automatic expect_word(input logic [17:0] w, input logic [5:0] pad);
        exp_q.push_back({(model_idx == WORDS - 1), (pad != 6'd0), 7'(model_idx), w});
        model_idx = (model_idx + 1) % WORDS;
    endtask

    task automatic idle(input int n);
        rs485_rx = 1'b1;
        repeat (n) @(negedge clk80MHz);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rs485_rx = 1'b0;
        repeat (CLKS) @(negedge clk80MHz);
        for (int i = 7; i >= 0; i--) begin
            rs485_rx = b[i];
            repeat (CLKS) @(negedge clk80MHz);
        end
        rs485_rx = stop_val;
        repeat (CLKS) @(negedge clk80MHz);
        rs485_rx = 1'b1;
    endtask

    task automatic send_word(input logic [17:0] w, input logic [5:0] pad);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        send_byte({w[17:16], pad}, 1'b1);
    endtask

    // Start bit plus the first few data bits of a frame, leaving the line mid-frame.
    task automatic send_partial(input logic [7:0] b);
        rs485_rx = 1'b0;
        repeat (CLKS) @(negedge clk80MHz);
        for (int i = 7; i >= 4; i--) begin
            rs485_rx = b[i];
            repeat (CLKS) @(negedge clk80MHz);
        end
        rs485_rx = 1'b0;
        repeat (CLKS / 2) @(negedge clk80MHz);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_en = 1'b1;
        rs485_rx = 1'b1;
        repeat (4) @(negedge clk80MHz);
        rst = 1'b0;
        model_idx = 0;
        exp_q.delete();
        idle(8);
    endtask

    task automatic test_reset();
        int g0;
        rst = 1'b1;
        rx_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rs485_rx = 1'($urandom_range(0, 1));
            @(negedge clk80MHz);
        end
        n_cmp++;
        if ({data_valid, block_done, frame_err, pad_err, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {data_valid, block_done, frame_err, pad_err, timeout_err});
        end
        g0 = n_got;
        rs485_rx = 1'b1;
        @(negedge clk80MHz);
        rst = 1'b0;
        idle(3 * CLKS);
        n_cmp++;
        if (data_out !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_data_out got=%h want=00000", data_out);
        end
        n_cmp++;
        if (word_idx !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_word_idx got=%0d want=0", word_idx);
        end
        n_cmp++;
        if (n_got - g0 !== 0) begin
            n_fail++;
            $display("FAIL reset_no_words got=%0d want=0", n_got - g0);
        end
        model_idx = 0;
        exp_q.delete();
    endtask

    task automatic test_basic_word();
        int g0, f0, t0;
        do_reset();
        g0 = n_got; f0 = fe_cnt; t0 = te_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC0, 1'b1);
        idle(20);
        n_cmp++;
        if (n_got - g0 !== 1) begin
            n_fail++;
            $display("FAIL basic_count got=%0d want=1", n_got - g0);
        end else begin
            n_cmp++;
            if (got_mem[g0] !== {1'b0, 1'b0, 7'd0, 18'h3A53C}) begin
                n_fail++;
                $display("FAIL basic_word got=%h want=%h", got_mem[g0],
                         {1'b0, 1'b0, 7'd0, 18'h3A53C});
            end
        end
        n_cmp++;
        if ((fe_cnt - f0) + (te_cnt - t0) !== 0) begin
            n_fail++;
            $display("FAIL basic_errors got=%0d want=0", (fe_cnt - f0) + (te_cnt - t0));
        end
    endtask

    task automatic test_block();
        int g0, f0, t0, nb;
        logic [17:0] w;
        do_reset();
        g0 = n_got; f0 = fe_cnt; t0 = te_cnt;
        for (int k = 0; k < WORDS; k++) begin
            w = 18'(k * 3);
            send_word(w, 6'd0);
            expect_word(w, 6'd0);
            idle($urandom_range(0, 40));
        end
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        idle(20);
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL block_count got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL block_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
        nb = 0;
        for (int i = g0; i < n_got; i++) if (got_mem[i][26]) nb++;
        n_cmp++;
        if (nb !== 1) begin
            n_fail++;
            $display("FAIL block_done_count got=%0d want=1", nb);
        end
        n_cmp++;
        if ((fe_cnt - f0) + (te_cnt - t0) !== 0) begin
            n_fail++;
            $display("FAIL block_errors got=%0d want=0", (fe_cnt - f0) + (te_cnt - t0));
        end
    endtask

    task automatic test_frame_err();
        int g0, f0;
        logic [17:0] w;
        do_reset();
        g0 = n_got; f0 = fe_cnt;
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        idle(2 * CLKS);
        n_cmp++;
        if (fe_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL frame_err_count got=%0d want=1", fe_cnt - f0);
        end
        n_cmp++;
        if (n_got - g0 !== 1) begin
            n_fail++;
            $display("FAIL frame_err_no_word got=%0d want=1", n_got - g0);
        end
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        idle(20);
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL frame_err_total got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL frame_err_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_pad();
        int g0;
        logic [7:0] b0, b1;
        do_reset();
        g0 = n_got;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(8'h41, 1'b1);
        expect_word({2'b01, b0, b1}, 6'h01);
        idle(20);
        n_cmp++;
        if (n_got - g0 !== 1) begin
            n_fail++;
            $display("FAIL pad_count got=%0d want=1", n_got - g0);
        end else begin
            n_cmp++;
            if (got_mem[g0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pad_word got=%h want=%h", got_mem[g0], exp_q[0]);
            end
            n_cmp++;
            if (got_mem[g0][17:16] !== 2'b01) begin
                n_fail++;
                $display("FAIL pad_top_bits got=%b want=01", got_mem[g0][17:16]);
            end
        end
    endtask

    task automatic test_timeout();
        int g0, t0;
        logic [17:0] w;
        do_reset();
        g0 = n_got; t0 = te_cnt;
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        idle(GAP_MAX - 2 * CLKS);
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        n_cmp++;
        if (te_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_early got=%0d want=0", te_cnt - t0);
        end
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        idle(GAP_MAX + 2 * CLKS);
        model_idx = 0;
        n_cmp++;
        if (te_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_count got=%0d want=1", te_cnt - t0);
        end
        w = 18'($urandom);
        send_word(w, 6'($urandom));
        expect_word(w, exp_pad_last(w));
        idle(20);
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_total got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL timeout_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    // The pad sent with the last word of test_timeout is recorded here so the
    // model can predict pad_err without reading anything back from the DUT.
    logic [5:0] last_pad_sent = '0;
    function automatic logic [5:0] exp_pad_last(input logic [17:0] w);
        return (w[0] ? 6'd0 : 6'd0) | last_pad_sent;
    endfunction

    task automatic test_glitch_abort();
        int g0, f0, t0;
        logic [17:0] wa, wb, wc, wd;
        do_reset();
        g0 = n_got; f0 = fe_cnt; t0 = te_cnt;
        rs485_rx = 1'b0;
        repeat (CLKS / 4) @(negedge clk80MHz);
        idle(3 * CLKS);
        n_cmp++;
        if ((n_got - g0) + (fe_cnt - f0) + (te_cnt - t0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobes got=%0d want=0", (n_got - g0) + (fe_cnt - f0) + (te_cnt - t0));
        end

        wa = 18'($urandom);
        send_word(wa, 6'd0);
        expect_word(wa, 6'd0);
        send_byte(8'($urandom), 1'b1);
        send_partial(8'($urandom));
        rx_en = 1'b0;
        repeat (5) @(negedge clk80MHz);
        rs485_rx = 1'b1;
        repeat (3 * CLKS) @(negedge clk80MHz);
        n_cmp++;
        if (data_out !== wa) begin
            n_fail++;
            $display("FAIL rx_en_hold got=%h want=%h", data_out, wa);
        end
        rx_en = 1'b1;
        model_idx = 0;
        idle(10);
        wb = 18'($urandom);
        send_word(wb, 6'd0);
        expect_word(wb, 6'd0);
        wc = 18'($urandom);
        send_word(wc, 6'd0);
        expect_word(wc, 6'd0);

        send_byte(8'($urandom), 1'b1);
        send_partial(8'($urandom));
        rst = 1'b1;
        repeat (3) @(negedge clk80MHz);
        rs485_rx = 1'b1;
        rst = 1'b0;
        model_idx = 0;
        idle(3 * CLKS);
        n_cmp++;
        if (data_out !== 18'h0 || word_idx !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_frame_rst got=%h/%0d want=00000/0", data_out, word_idx);
        end
        wd = 18'($urandom);
        send_word(wd, 6'd0);
        expect_word(wd, 6'd0);
        idle(20);
        n_cmp++;
        if ((fe_cnt - f0) + (te_cnt - t0) !== 0) begin
            n_fail++;
            $display("FAIL abort_errors got=%0d want=0", (fe_cnt - f0) + (te_cnt - t0));
        end
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_total got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL abort_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int g0;
        logic [17:0] w;
        logic [5:0]  p;
        do_reset();
        g0 = n_got;
        for (int i = 0; i < 10; i++) begin
            w = 18'($urandom);
            p = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            send_word(w, p);
            expect_word(w, p);
        end
        idle(20);
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_strobe_rules();
        n_cmp++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_overlap got=%0d want=0", overlap_cnt);
        end
        n_cmp++;
        if (orphan_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_orphan got=%0d want=0", orphan_cnt);
        end
        n_cmp++;
        if (long_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_width got=%0d want=0", long_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_pad();
        test_frame_err();
        last_pad_sent = 6'($urandom_range(1, 63));
        test_timeout_with_pad();
        test_glitch_abort();
        test_back_to_back();
        test_block();
        test_strobe_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Runs test_timeout with the final word carrying last_pad_sent as its pad bits.
    task automatic test_timeout_with_pad();
        test_timeout_body();
    endtask

    task automatic test_timeout_body();
        int g0, t0;
        logic [17:0] w;
        do_reset();
        g0 = n_got; t0 = te_cnt;
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        idle(GAP_MAX - 2 * CLKS);
        w = 18'($urandom);
        send_word(w, 6'd0);
        expect_word(w, 6'd0);
        n_cmp++;
        if (te_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_early got=%0d want=0", te_cnt - t0);
        end
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        idle(GAP_MAX + 2 * CLKS);
        model_idx = 0;
        n_cmp++;
        if (te_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_count got=%0d want=1", te_cnt - t0);
        end
        w = 18'($urandom);
        send_word(w, last_pad_sent);
        expect_word(w, last_pad_sent);
        idle(20);
        n_cmp++;
        if (n_got - g0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_total got=%0d want=%0d", n_got - g0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_mem[g0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL timeout_word[%0d] got=%h want=%h", i, got_mem[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

endmodule
